// File: rtl/alarm_bank.sv
// Multi-channel alarm controller: per-channel arm/ring/snooze FSMs with match-edge
// detection against the running BCD time, shared snooze/stop buttons and a 1 Hz buzzer.
module alarm_bank #(
   parameter  int NUM_ALARMS  = 4,
   parameter  int DIGITS      = 4,
   parameter  int RING_SECS   = 60,
   parameter  int SNOOZE_SECS = 300,
   localparam int ID_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                         uclock,
   input  logic                         rst_n,
   input  logic                         sec_tick,
   input  logic [4*DIGITS-1:0]          t_bcd,
   input  logic [NUM_ALARMS*4*DIGITS-1:0] a_bcd,
   input  logic [NUM_ALARMS-1:0]        arm_btn,
   input  logic                         snooze_btn,
   input  logic                         stop_btn,
   output logic [NUM_ALARMS-1:0]        armed,
   output logic [NUM_ALARMS-1:0]        ringing,
   output logic [NUM_ALARMS-1:0]        snoozing,
   output logic [ID_W-1:0]              ring_id,
   output logic                         buzzer
);

   localparam int TW    = 4*DIGITS;
   localparam int CMAX  = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
   localparam int CNT_W = $clog2(CMAX + 1);

   localparam logic [1:0] S_DIS  = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_RING = 2'd2;
   localparam logic [1:0] S_SNZ  = 2'd3;

   localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
   localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SECS - 1);

   logic [1:0]            r_state      [NUM_ALARMS];
   logic [CNT_W-1:0]      r_cnt        [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] r_match_prev;
   logic [NUM_ALARMS-1:0] r_arm_prev;
   logic                  r_snz_prev;
   logic                  r_stop_prev;
   logic                  r_any_ring;
   logic                  r_beep_phase;

   logic [1:0]            w_state_nxt  [NUM_ALARMS];
   logic [CNT_W-1:0]      w_cnt_nxt    [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] w_match;
   logic [NUM_ALARMS-1:0] w_mev;
   logic [NUM_ALARMS-1:0] w_arm_edge;
   logic [NUM_ALARMS-1:0] w_armed_nxt;
   logic [NUM_ALARMS-1:0] w_ring_nxt;
   logic [NUM_ALARMS-1:0] w_snz_nxt;
   logic [ID_W-1:0]       w_id_nxt;
   logic                  w_snz_edge;
   logic                  w_stop_edge;
   logic                  w_any_ring_nxt;
   logic                  w_phase_nxt;

   always_comb begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
         w_match[k] = (t_bcd == a_bcd[k*TW +: TW]);
      end
   end

   assign w_mev       = w_match & ~r_match_prev;
   assign w_arm_edge  = arm_btn & ~r_arm_prev;
   assign w_snz_edge  = snooze_btn & ~r_snz_prev;
   assign w_stop_edge = stop_btn & ~r_stop_prev;

   // Branch order encodes priority: arm > stop > snooze > timeout/expiry > match.
   always_comb begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
         w_state_nxt[k] = r_state[k];
         w_cnt_nxt[k]   = r_cnt[k];
         case (r_state[k])
            S_DIS: begin
               if (w_arm_edge[k]) w_state_nxt[k] = S_ARM;
            end
            S_ARM: begin
               if (w_arm_edge[k]) begin
                  w_state_nxt[k] = S_DIS;
               end else if (w_mev[k]) begin
                  w_state_nxt[k] = S_RING;
                  w_cnt_nxt[k]   = '0;
               end
            end
            S_RING: begin
               if (w_arm_edge[k]) begin
                  w_state_nxt[k] = S_DIS;
               end else if (w_stop_edge) begin
                  w_state_nxt[k] = S_ARM;
               end else if (w_snz_edge) begin
                  w_state_nxt[k] = S_SNZ;
                  w_cnt_nxt[k]   = '0;
               end else if (sec_tick) begin
                  if (r_cnt[k] == RING_LAST) begin
                     w_state_nxt[k] = S_ARM;
                     w_cnt_nxt[k]   = '0;
                  end else begin
                     w_cnt_nxt[k]   = r_cnt[k] + CNT_W'(1);
                  end
               end
            end
            S_SNZ: begin
               if (w_arm_edge[k]) begin
                  w_state_nxt[k] = S_DIS;
               end else if (w_stop_edge) begin
                  w_state_nxt[k] = S_ARM;
               end else if (sec_tick) begin
                  if (r_cnt[k] == SNZ_LAST) begin
                     w_state_nxt[k] = S_RING;
                     w_cnt_nxt[k]   = '0;
                  end else begin
                     w_cnt_nxt[k]   = r_cnt[k] + CNT_W'(1);
                  end
               end
            end
            default: w_state_nxt[k] = S_DIS;
         endcase
      end
   end

   // Outputs are registered from the next-state decode so they track state with no extra lag.
   always_comb begin
      w_id_nxt = '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
         w_armed_nxt[k] = (w_state_nxt[k] != S_DIS);
         w_ring_nxt[k]  = (w_state_nxt[k] == S_RING);
         w_snz_nxt[k]   = (w_state_nxt[k] == S_SNZ);
      end
      for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
         if (w_ring_nxt[k]) w_id_nxt = ID_W'(k);
      end
   end

   assign w_any_ring_nxt = |w_ring_nxt;

   always_comb begin
      w_phase_nxt = r_beep_phase;
      if (w_any_ring_nxt && !r_any_ring) begin
         w_phase_nxt = 1'b1;
      end else if (w_any_ring_nxt && sec_tick) begin
         w_phase_nxt = ~r_beep_phase;
      end
   end

   always_ff @(posedge uclock or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_ALARMS; k++) begin
            r_state[k] <= S_DIS;
            r_cnt[k]   <= '0;
         end
         r_match_prev <= '0;
         r_arm_prev   <= '0;
         r_snz_prev   <= 1'b0;
         r_stop_prev  <= 1'b0;
         r_any_ring   <= 1'b0;
         r_beep_phase <= 1'b0;
         armed        <= '0;
         ringing      <= '0;
         snoozing     <= '0;
         ring_id      <= '0;
         buzzer       <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_ALARMS; k++) begin
            r_state[k] <= w_state_nxt[k];
            r_cnt[k]   <= w_cnt_nxt[k];
         end
         r_match_prev <= w_match;
         r_arm_prev   <= arm_btn;
         r_snz_prev   <= snooze_btn;
         r_stop_prev  <= stop_btn;
         r_any_ring   <= w_any_ring_nxt;
         r_beep_phase <= w_phase_nxt;
         armed        <= w_armed_nxt;
         ringing      <= w_ring_nxt;
         snoozing     <= w_snz_nxt;
         ring_id      <= w_id_nxt;
         buzzer       <= w_phase_nxt & w_any_ring_nxt;
      end
   end

endmodule
